draw_layer_scheduler: RTL and testbench
=======================================

Name: draw_layer_scheduler

Overview:
- Sequences up to N_LAYERS pixel-iterating draw units (background, sprites, overlays) once per frame, lowest index first, so later layers paint over earlier ones.
- Owns each unit's start handshake and multiplexes the active unit's pixel stream onto the single VGA adapter write port.
- Suppresses writes of a transparent colour key for all layers above layer 0.
- Sits between the game-state FSM (which issues frame_start and layer enables) and the VGA adapter.

Parameters:
- N_LAYERS, 4, number of draw units; 2..8.
- LAYER_W, 3, width of the layer index; must satisfy 2^LAYER_W >= N_LAYERS.
- TRANSPARENT, 8'hE3, colour key; layers 1..N_LAYERS-1 never write this colour.
- RELEASE_CYCLES, 2, cycles start is held low after a unit's done, letting the unit return to idle.
- TIMEOUT, 20'd40000, maximum cycles spent in DRAW per layer before the layer is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; one clock; reset is synchronous and active-high.
- frame_start  in  1  single-cycle request to draw one frame.
- layer_en  in  N_LAYERS  per-layer enable; sampled only on an accepted frame_start.
- unit_x  in  N_LAYERS*8  x outputs of the units; layer i occupies bits [8i+7:8i].
- unit_y  in  N_LAYERS*7  y outputs of the units; layer i occupies bits [7i+6:7i].
- unit_colour  in  N_LAYERS*8  colour outputs of the units; layer i occupies bits [8i+7:8i].
- unit_we  in  N_LAYERS  writeEn outputs of the units.
- unit_done  in  N_LAYERS  done outputs of the units.
- unit_start  out  N_LAYERS  start input of each unit; at most one bit is high at a time.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  8  pixel colour to the adapter.
- vga_we  out  1  pixel write enable to the adapter.
- busy  out  1  high in every state except IDLE.
- active_layer  out  LAYER_W  index currently scanned or drawn.
- frame_done  out  1  one-cycle pulse when a frame completes.
- overrun  out  1  one-cycle pulse when frame_start arrives while busy.
- timeout  out  1  one-cycle pulse when a layer is aborted by TIMEOUT.

Behaviour:
- Reset: state IDLE; idx=0; mask=0; watchdog=0. All outputs are 0: unit_start, vga_x, vga_y, vga_colour, vga_we, busy, active_layer, frame_done, overrun, timeout.
- Reset has priority over every other input and takes effect mid-frame. unit_start drops in the following cycle; units are not otherwise cleared.
- IDLE: when frame_start=1, latch mask<=layer_en, set idx<=0, go to SCAN. Otherwise stay in IDLE.
- SCAN (one layer examined per cycle):
  - mask[idx]=1: go to DRAW and clear watchdog.
  - mask[idx]=0 and idx==N_LAYERS-1: go to FINISH.
  - Otherwise: idx<=idx+1 and stay in SCAN.
- DRAW:
  - unit_start[idx]=1; watchdog increments each cycle.
  - unit_done[idx]=1: go to RELEASE.
  - Else if watchdog==TIMEOUT-1: pulse timeout and go to RELEASE.
- RELEASE:
  - unit_start=0 for exactly RELEASE_CYCLES cycles.
  - Then go to FINISH if idx==N_LAYERS-1; otherwise idx<=idx+1 and go to SCAN.
  - unit_done is ignored in this state, because stale done is still high from the unit's previous pass.
- FINISH: frame_done=1 for one cycle, then go to IDLE.
- frame_start while busy is dropped; overrun pulses in the same cycle it is sampled. A frame_start in the FINISH cycle is also dropped and also flagged.
- Pixel path (registered, one cycle of latency):
  - Each edge, vga_x, vga_y and vga_colour take the slice of layer idx whenever the state is DRAW.
  - vga_we<=unit_we[idx] & (state==DRAW) & ~(idx!=0 & unit_colour slice==TRANSPARENT).
  - Outside DRAW, vga_we<=0 and vga_x/vga_y/vga_colour hold their last values.
- unit_we of non-selected layers is ignored.
- A frame with mask=0 spends N_LAYERS cycles in SCAN, one cycle in FINISH, and generates no unit_start.
- Layer 0 writes TRANSPARENT normally.
- active_layer=idx in SCAN, DRAW and RELEASE; otherwise 0.

Test Plan:
- Reset, then frame_start with layer_en=4'b0000: busy for 5 cycles; frame_done pulses in cycle 6 after frame_start; unit_start stays 0 throughout; vga_we stays 0.
- layer_en=4'b0101, behavioural units taking 10 cycles each: unit_start[0] asserted first, then unit_start[2]; unit_start[1] and unit_start[3] never rise; exactly one frame_done; each unit_start low for ≥2 cycles after its unit's done.
- Layer 1 emits colours E3, 1C, E3 with we=1: vga_we sequence is 0, 1, 0, each one cycle after the input; the same stream on layer 0 gives 1, 1, 1.
- frame_start pulsed again 3 cycles into a frame: overrun=1 for that cycle; the current frame completes normally; no second frame is started.
- Layer 0 unit never asserts done, TIMEOUT=16: timeout pulses after 16 DRAW cycles; scheduler proceeds to layer 1; frame_done is still issued.
- reset asserted while in DRAW on layer 2: next cycle unit_start=0, busy=0, vga_we=0; a new frame_start then begins cleanly at layer 0.

Source files
------------

// File: rtl/draw_layer_scheduler.sv
// Purpose: runs up to N_LAYERS draw units once per frame, lowest index first, and muxes the active unit onto the VGA write port.
// Latency: pixel path is registered, so each unit pixel reaches the vga_* outputs one cycle later; control outputs are combinational from state.
// Backpressure: none; a frame_start that arrives while a frame is in flight is dropped and flagged on overrun.
module draw_layer_scheduler #(
    parameter int          N_LAYERS       = 4,
    parameter int          LAYER_W        = 3,
    parameter logic [7:0]  TRANSPARENT    = 8'hE3,
    parameter int          RELEASE_CYCLES = 2,
    parameter logic [19:0] TIMEOUT        = 20'd40000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [N_LAYERS-1:0]   layer_en,
    input  logic [N_LAYERS*8-1:0] unit_x,
    input  logic [N_LAYERS*7-1:0] unit_y,
    input  logic [N_LAYERS*8-1:0] unit_colour,
    input  logic [N_LAYERS-1:0]   unit_we,
    input  logic [N_LAYERS-1:0]   unit_done,
    output logic [N_LAYERS-1:0]   unit_start,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [7:0]            vga_colour,
    output logic                  vga_we,
    output logic                  busy,
    output logic [LAYER_W-1:0]    active_layer,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAW,
        S_RELEASE,
        S_FINISH
    } state_t;

    localparam int                  RC_W     = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [LAYER_W-1:0]  LAST     = LAYER_W'(N_LAYERS - 1);
    localparam logic [RC_W-1:0]     REL_LAST = RC_W'(RELEASE_CYCLES - 1);
    localparam logic [19:0]         WD_LAST  = TIMEOUT - 20'd1;

    state_t                state_q, state_d;
    logic [LAYER_W-1:0]    idx_q, idx_d;
    logic [N_LAYERS-1:0]   mask_q, mask_d;
    logic [19:0]           wd_q, wd_d;
    logic [RC_W-1:0]       rc_q, rc_d;

    logic [7:0]            vga_x_q, vga_colour_q;
    logic [6:0]            vga_y_q;
    logic                  vga_we_q;

    logic                  sel_mask, sel_done, sel_we;
    logic [7:0]            sel_x, sel_col;
    logic [6:0]            sel_y;
    logic                  drawing;

    // Pick out the signals of the layer addressed by idx; a compare-per-layer mux keeps idx width independent of N_LAYERS.
    always_comb begin
        sel_mask = 1'b0;
        sel_done = 1'b0;
        sel_we   = 1'b0;
        sel_x    = '0;
        sel_y    = '0;
        sel_col  = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (idx_q == LAYER_W'(i)) begin
                sel_mask = mask_q[i];
                sel_done = unit_done[i];
                sel_we   = unit_we[i];
                sel_x    = unit_x[8*i +: 8];
                sel_y    = unit_y[7*i +: 7];
                sel_col  = unit_colour[8*i +: 8];
            end
        end
    end

    assign drawing = (state_q == S_DRAW);

    // Next-state logic and control outputs for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        wd_d         = wd_q;
        rc_d         = rc_q;
        timeout      = 1'b0;
        busy         = (state_q != S_IDLE);
        frame_done   = (state_q == S_FINISH);
        overrun      = frame_start && (state_q != S_IDLE);
        active_layer = '0;
        unit_start   = '0;

        if (state_q == S_SCAN || state_q == S_DRAW || state_q == S_RELEASE) begin
            active_layer = idx_q;
        end

        for (int i = 0; i < N_LAYERS; i++) begin
            unit_start[i] = drawing && (idx_q == LAYER_W'(i));
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    mask_d  = layer_en;
                    idx_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (sel_mask) begin
                    wd_d    = '0;
                    state_d = S_DRAW;
                end else if (idx_q == LAST) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DRAW: begin
                wd_d = wd_q + 20'd1;
                if (sel_done) begin
                    rc_d    = '0;
                    state_d = S_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    timeout = 1'b1;
                    rc_d    = '0;
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // done from the unit is deliberately ignored here: it can still be high from the pass just ended.
                rc_d = rc_q + 1'b1;
                if (rc_q == REL_LAST) begin
                    if (idx_q == LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_SCAN;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            wd_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            wd_q    <= wd_d;
            rc_q    <= rc_d;
        end
    end

    // Registered pixel path: follow the active unit in DRAW, hold coordinates otherwise, drop transparent pixels above layer 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_we_q     <= 1'b0;
        end else begin
            vga_we_q <= drawing && sel_we && !((idx_q != '0) && (sel_col == TRANSPARENT));
            if (drawing) begin
                vga_x_q      <= sel_x;
                vga_y_q      <= sel_y;
                vga_colour_q <= sel_col;
            end
        end
    end

    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_we     = vga_we_q;

endmodule

// File: tb/tb_draw_layer_scheduler.sv
module tb_draw_layer_scheduler;

    localparam int NL  = 4;
    localparam int DUR = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_start;
    logic [NL-1:0]   layer_en;
    logic [NL*8-1:0] unit_x;
    logic [NL*7-1:0] unit_y;
    logic [NL*8-1:0] unit_colour;
    logic [NL-1:0]   unit_we;
    logic [NL-1:0]   unit_done;
    logic [NL-1:0]   unit_start;
    logic [7:0]      vga_x;
    logic [6:0]      vga_y;
    logic [7:0]      vga_colour;
    logic            vga_we;
    logic            busy;
    logic [2:0]      active_layer;
    logic            frame_done;
    logic            overrun;
    logic            timeout;

    int tests = 0;
    int fails = 0;

    draw_layer_scheduler #(
        .N_LAYERS(NL), .LAYER_W(3), .TRANSPARENT(8'hE3),
        .RELEASE_CYCLES(2), .TIMEOUT(20'd16)
    ) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .layer_en(layer_en),
        .unit_x(unit_x), .unit_y(unit_y), .unit_colour(unit_colour),
        .unit_we(unit_we), .unit_done(unit_done), .unit_start(unit_start),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_we(vga_we),
        .busy(busy), .active_layer(active_layer), .frame_done(frame_done),
        .overrun(overrun), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Behavioural draw units: DUR pixels after start, then done held until start drops; hang[i] never finishes.
    logic [NL-1:0] hang;
    logic          m_run [NL];
    logic          m_done[NL];
    logic [7:0]    m_cnt [NL];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (reset || !unit_start[i]) begin
                m_run[i]  <= 1'b0;
                m_done[i] <= 1'b0;
                m_cnt[i]  <= '0;
            end else if (!m_run[i] && !m_done[i]) begin
                m_run[i] <= 1'b1;
                m_cnt[i] <= '0;
            end else if (m_run[i]) begin
                if (!hang[i] && m_cnt[i] == 8'(DUR - 1)) begin
                    m_run[i]  <= 1'b0;
                    m_done[i] <= 1'b1;
                end else begin
                    m_cnt[i] <= m_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Manual override of one or more units for colour-key stimulus.
    logic [NL-1:0] man_en;
    logic          man_we, man_done;
    logic [7:0]    man_x, man_col;
    logic [6:0]    man_y;

    logic       src_we  [NL];
    logic       src_done[NL];
    logic [7:0] src_x   [NL];
    logic [6:0] src_y   [NL];
    logic [7:0] src_col [NL];

    always_comb begin
        unit_x = '0; unit_y = '0; unit_colour = '0; unit_we = '0; unit_done = '0;
        for (int i = 0; i < NL; i++) begin
            src_we[i]   = m_run[i] & unit_start[i];
            src_done[i] = m_done[i];
            src_x[i]    = m_cnt[i];
            src_y[i]    = 7'(i);
            src_col[i]  = 8'h10 + 8'(i);
            if (man_en[i]) begin
                src_we[i]   = man_we;
                src_done[i] = man_done;
                src_x[i]    = man_x;
                src_y[i]    = man_y;
                src_col[i]  = man_col;
            end
            unit_x[8*i +: 8]      = src_x[i];
            unit_y[7*i +: 7]      = src_y[i];
            unit_colour[8*i +: 8] = src_col[i];
            unit_we[i]            = src_we[i];
            unit_done[i]          = src_done[i];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pixels the units offer are pushed at negedge; registered output is popped one cycle later.
    logic [22:0] sb_q[$];

    always @(negedge clk) begin
        logic [22:0] exp;
        if (vga_we === 1'b1) begin
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
            chk("sb_pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp));
        end
        if (!reset) begin
            for (int i = 0; i < NL; i++) begin
                if (src_we[i] && (i == 0 || src_col[i] != 8'hE3)) begin
                    sb_q.push_back({src_x[i], src_y[i], src_col[i]});
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Per-frame statistics gathered while stepping to frame_done.
    int fd_cnt, to_cnt, to_at, us0_cnt, rel_viol, onehot_viol, done_events, rel_pend;
    int order[$];
    logic [NL-1:0] prev_us;

    task automatic run_frame(input int budget);
        int n;
        fd_cnt = 0; to_cnt = 0; to_at = -1; us0_cnt = 0; rel_viol = 0;
        onehot_viol = 0; done_events = 0; rel_pend = 0; prev_us = '0;
        order.delete();
        for (n = 0; n < budget; n++) begin
            if (unit_start[0]) us0_cnt++;
            if (timeout) begin to_cnt++; to_at = us0_cnt; end
            if ($countones(unit_start) > 1) onehot_viol++;
            for (int i = 0; i < NL; i++)
                if (unit_start[i] && !prev_us[i]) order.push_back(i);
            prev_us = unit_start;
            if (rel_pend > 0) begin
                if (unit_start != '0) rel_viol++;
                rel_pend--;
            end
            for (int i = 0; i < NL; i++)
                if (unit_done[i] && unit_start[i]) begin
                    rel_pend = 2;
                    done_events++;
                end
            if (frame_done) begin
                fd_cnt++;
                break;
            end
            step();
        end
        if (n == budget) chk("frame_budget", 32'(n), 32'(budget - 1));
        step();
    endtask

    task automatic start_frame(input logic [NL-1:0] en);
        layer_en    = en;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_start(input int layer);
        int n;
        for (n = 0; n < 40 && !unit_start[layer]; n++) step();
        chk("wait_unit_start", 32'(unit_start[layer]), 32'd1);
    endtask

    // Drive E3, 1C, E3 on one layer and check the registered write enables.
    task automatic colour_run(input int layer, input logic [2:0] exp_we);
        man_en = NL'(1) << layer;
        man_x = 8'd7; man_y = 7'd3; man_we = 1'b0; man_done = 1'b0;
        start_frame(NL'(1) << layer);
        wait_start(layer);
        man_we = 1'b1; man_col = 8'hE3; man_x = 8'd1;
        step();
        man_col = 8'h1C; man_x = 8'd2;
        chk("colour_we0", 32'(vga_we), 32'(exp_we[0]));
        step();
        man_col = 8'hE3; man_x = 8'd3;
        chk("colour_we1", 32'(vga_we), 32'(exp_we[1]));
        step();
        man_we = 1'b0; man_done = 1'b1;
        chk("colour_we2", 32'(vga_we), 32'(exp_we[2]));
        step();
        man_done = 1'b0;
        run_frame(60);
        chk("colour_frame_done", 32'(fd_cnt), 32'd1);
        man_en = '0;
    endtask

    initial begin
        int busy_cnt, fd_cyc, us_any, we_any, busy_after;
        reset = 1'b1; frame_start = 1'b0; layer_en = '0; hang = '0;
        man_en = '0; man_we = 1'b0; man_done = 1'b0;
        man_x = '0; man_y = '0; man_col = '0;
        step(); step(); step();

        // Reset state: every output low.
        chk("rst_unit_start", 32'(unit_start), 32'd0);
        chk("rst_vga", 32'({vga_x, vga_y, vga_colour, vga_we}), 32'd0);
        chk("rst_ctrl", 32'({busy, active_layer, frame_done, overrun, timeout}), 32'd0);
        reset = 1'b0;
        step();

        // Empty mask: 4 SCAN + 1 FINISH, frame_done in cycle 6 counting the frame_start cycle as 1.
        busy_cnt = 0; fd_cyc = 0; us_any = 0; we_any = 0;
        start_frame(4'b0000);
        for (int c = 2; c <= 10; c++) begin
            if (busy) busy_cnt++;
            if (frame_done) fd_cyc = c;
            if (unit_start != '0) us_any++;
            if (vga_we) we_any++;
            step();
        end
        chk("empty_busy_cycles", 32'(busy_cnt), 32'd5);
        chk("empty_frame_done_cycle", 32'(fd_cyc), 32'd6);
        chk("empty_no_start", 32'(us_any), 32'd0);
        chk("empty_no_we", 32'(we_any), 32'd0);

        // Layers 0 and 2 with 10-pixel units.
        start_frame(4'b0101);
        run_frame(200);
        chk("l02_frame_done", 32'(fd_cnt), 32'd1);
        chk("l02_start_count", 32'(order.size()), 32'd2);
        chk("l02_first", 32'((order.size() > 0) ? order[0] : 99), 32'd0);
        chk("l02_second", 32'((order.size() > 1) ? order[1] : 99), 32'd2);
        chk("l02_done_events", 32'(done_events), 32'd2);
        chk("l02_release_gap", 32'(rel_viol), 32'd0);
        chk("l02_onehot", 32'(onehot_viol), 32'd0);

        // Colour key suppressed above layer 0 only.
        colour_run(1, 3'b010);
        colour_run(0, 3'b111);

        // frame_start while busy is dropped and flagged.
        start_frame(4'b0001);
        step(); step();
        frame_start = 1'b1;
        #1;
        chk("overrun_pulse", 32'(overrun), 32'd1);
        step();
        frame_start = 1'b0;
        #1;
        chk("overrun_clear", 32'(overrun), 32'd0);
        run_frame(200);
        chk("overrun_frame_done", 32'(fd_cnt), 32'd1);
        busy_after = 0;
        for (int c = 0; c < 20; c++) begin
            if (busy) busy_after++;
            step();
        end
        chk("overrun_no_second_frame", 32'(busy_after), 32'd0);

        // Layer 0 hangs: aborted on its 16th DRAW cycle, layer 1 still runs.
        hang = 4'b0001;
        start_frame(4'b0011);
        run_frame(200);
        chk("to_pulses", 32'(to_cnt), 32'd1);
        chk("to_draw_cycles", 32'(to_at), 32'd16);
        chk("to_layer0_cycles", 32'(us0_cnt), 32'd16);
        chk("to_next_layer", 32'((order.size() > 1) ? order[1] : 99), 32'd1);
        chk("to_frame_done", 32'(fd_cnt), 32'd1);
        hang = '0;

        // Reset in the middle of layer 2's DRAW, then a clean frame.
        start_frame(4'b0100);
        wait_start(2);
        step(); step(); step();
        reset = 1'b1;
        step();
        sb_q.delete();
        chk("midrst_unit_start", 32'(unit_start), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_vga_we", 32'(vga_we), 32'd0);
        reset = 1'b0;
        step();
        start_frame(4'b0001);
        run_frame(200);
        chk("postrst_first", 32'((order.size() > 0) ? order[0] : 99), 32'd0);
        chk("postrst_frame_done", 32'(fd_cnt), 32'd1);

        step(); step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
